// File: rtl/ctrl_pkg.sv
// Shared types and constants for the multicycle main control FSM.
// Contents: state_t encoding, instruction-class codes, datapath mux-select codes,
// and the packed control word produced by the output decoder.
package ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECUTER = 4'd6,
        EXECUTEI = 4'd7,
        ALUWB    = 4'd8,
        BRANCH   = 4'd9
    } state_t;

    // Instruction class, Instr[27:26]; 2'b11 is undefined.
    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;

    // ALU A operand select
    localparam logic [1:0] SRCA_RN  = 2'b00;
    localparam logic [1:0] SRCA_PC  = 2'b01;

    // ALU B operand select
    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    // Result mux select
    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    typedef struct packed {
        logic       mem_req;
        logic       ir_write;
        logic       next_pc;
        logic       reg_w;
        logic       mem_w;
        logic       branch;
        logic       adr_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] result_src;
        logic       alu_op;
    } ctrl_word_t;

endpackage

// File: rtl/ctrl_fsm_outdec.sv
// Moore output decode: state -> raw control word (before bus-ready qualification).
// Ports: state_i current FSM state; cw_o control word, all fields 0 unless the state drives them.
// Purely combinational, zero latency; no flow control of its own.
module ctrl_fsm_outdec
    import ctrl_pkg::*;
(
    input  state_t     state_i,
    output ctrl_word_t cw_o
);

    always_comb begin
        cw_o = '0;
        case (state_i)
            FETCH: begin
                cw_o.adr_src    = 1'b0;
                cw_o.alu_src_a  = SRCA_PC;
                cw_o.alu_src_b  = SRCB_FOUR;
                cw_o.result_src = RES_ALU;
                cw_o.ir_write   = 1'b1;
                cw_o.next_pc    = 1'b1;
                cw_o.mem_req    = 1'b1;
            end
            DECODE: begin
                // PC+4 computed again so R15 reads as PC+8 during decode
                cw_o.alu_src_a  = SRCA_PC;
                cw_o.alu_src_b  = SRCB_FOUR;
                cw_o.result_src = RES_ALU;
            end
            MEMADR: begin
                cw_o.alu_src_a  = SRCA_RN;
                cw_o.alu_src_b  = SRCB_IMM;
            end
            MEMREAD: begin
                cw_o.adr_src    = 1'b1;
                cw_o.result_src = RES_ALUOUT;
                cw_o.mem_req    = 1'b1;
            end
            MEMWB: begin
                cw_o.result_src = RES_DATA;
                cw_o.reg_w      = 1'b1;
            end
            MEMWRITE: begin
                cw_o.adr_src    = 1'b1;
                cw_o.result_src = RES_ALUOUT;
                cw_o.mem_w      = 1'b1;
                cw_o.mem_req    = 1'b1;
            end
            EXECUTER: begin
                cw_o.alu_src_a  = SRCA_RN;
                cw_o.alu_src_b  = SRCB_REG;
                cw_o.alu_op     = 1'b1;
            end
            EXECUTEI: begin
                cw_o.alu_src_a  = SRCA_RN;
                cw_o.alu_src_b  = SRCB_IMM;
                cw_o.alu_op     = 1'b1;
            end
            ALUWB: begin
                cw_o.result_src = RES_ALUOUT;
                cw_o.reg_w      = 1'b1;
            end
            BRANCH: begin
                cw_o.alu_src_a  = SRCA_RN;
                cw_o.alu_src_b  = SRCB_IMM;
                cw_o.result_src = RES_ALU;
                cw_o.branch     = 1'b1;
            end
            default: cw_o = '0;
        endcase
    end

endmodule

// File: rtl/ctrl_fsm.sv
// Multicycle main control FSM: fetch/decode/execute/memory/writeback sequencing, Moore outputs.
// Ports: clk, reset (async active-low), Op/Funct instruction fields, HREADY bus ready;
// control-word outputs and debug state. CTRL_FSM_WAITSTATE_EN enables AHB wait-state stalls.
module ctrl_fsm
    import ctrl_pkg::*;
#(
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [1:0]         Op,
    input  logic [5:0]         Funct,
    input  logic               HREADY,
    output logic               MemReq,
    output logic               IRWrite,
    output logic               NextPC,
    output logic               RegW,
    output logic               MemW,
    output logic               Branch,
    output logic               AdrSrc,
    output logic [1:0]         ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic [1:0]         ResultSrc,
    output logic               ALUOp,
    output logic [STATE_W-1:0] state
);

    state_t     state_q;
    state_t     state_d;
    ctrl_word_t cw;
    logic       bus_done;

    // Only the I and L/S bits steer the sequence; the rest belong to the ALU decoder.
    logic unused_funct;
    assign unused_funct = ^Funct[4:1];

`ifdef CTRL_FSM_WAITSTATE_EN
    assign bus_done = HREADY;
`else
    logic unused_hready;
    assign unused_hready = HREADY;
    assign bus_done      = 1'b1;
`endif

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= FETCH;
        else        state_q <= state_d;
    end

    // Next-state logic; bus-facing states hold until the transfer completes.
    always_comb begin
        state_d = state_q;
        case (state_q)
            FETCH:    if (bus_done) state_d = DECODE;
            DECODE: begin
                case (Op)
                    OP_MEM:  state_d = MEMADR;
                    OP_DP:   state_d = Funct[5] ? EXECUTEI : EXECUTER;
                    OP_BR:   state_d = BRANCH;
                    default: state_d = FETCH;
                endcase
            end
            MEMADR:   state_d = Funct[0] ? MEMREAD : MEMWRITE;
            MEMREAD:  if (bus_done) state_d = MEMWB;
            MEMWRITE: if (bus_done) state_d = FETCH;
            EXECUTER: state_d = ALUWB;
            EXECUTEI: state_d = ALUWB;
            MEMWB:    state_d = FETCH;
            ALUWB:    state_d = FETCH;
            BRANCH:   state_d = FETCH;
            default:  state_d = FETCH;
        endcase
    end

    ctrl_fsm_outdec u_outdec (
        .state_i (state_q),
        .cw_o    (cw)
    );

    // Output logic. IRWrite/NextPC fire only on the completing fetch cycle and are
    // forced low while reset is held, even though the state already reads FETCH.
    always_comb begin
        MemReq    = cw.mem_req;
        IRWrite   = cw.ir_write & reset & bus_done;
        NextPC    = cw.next_pc  & reset & bus_done;
        RegW      = cw.reg_w;
        MemW      = cw.mem_w;
        Branch    = cw.branch;
        AdrSrc    = cw.adr_src;
        ALUSrcA   = cw.alu_src_a;
        ALUSrcB   = cw.alu_src_b;
        ResultSrc = cw.result_src;
        ALUOp     = cw.alu_op;
    end

    assign state = STATE_W'(state_q);

endmodule

// File: tb/tb_ctrl_fsm.sv
// Directed self-checking bench for ctrl_fsm.
// Walks reset, DP-immediate, DP-register, load, store, branch and undefined paths,
// plus FETCH/MEMWRITE stalls when CTRL_FSM_WAITSTATE_EN is defined.
module tb_ctrl_fsm;

    logic       clk;
    logic       reset;
    logic [1:0] Op;
    logic [5:0] Funct;
    logic       HREADY;
    logic       MemReq, IRWrite, NextPC, RegW, MemW, Branch, AdrSrc, ALUOp;
    logic [1:0] ALUSrcA, ALUSrcB, ResultSrc;
    logic [3:0] state;

    int checks   = 0;
    int failures = 0;

    ctrl_fsm #(.STATE_W(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .Op        (Op),
        .Funct     (Funct),
        .HREADY    (HREADY),
        .MemReq    (MemReq),
        .IRWrite   (IRWrite),
        .NextPC    (NextPC),
        .RegW      (RegW),
        .MemW      (MemW),
        .Branch    (Branch),
        .AdrSrc    (AdrSrc),
        .ALUSrcA   (ALUSrcA),
        .ALUSrcB   (ALUSrcB),
        .ResultSrc (ResultSrc),
        .ALUOp     (ALUOp),
        .state     (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset  = 1'b0;
        Op     = 2'b00;
        Funct  = 6'b000000;
        HREADY = 1'b1;

        // Held in reset across edges
        repeat (2) @(negedge clk);
        chk("rst_state",   state,   8'd0);
        chk("rst_irwrite", IRWrite, 8'd0);
        chk("rst_nextpc",  NextPC,  8'd0);
        chk("rst_memreq",  MemReq,  8'd1);
        chk("rst_srcb",    ALUSrcB, 8'd2);

        // Release between edges; FETCH completes on the first rising edge
        reset = 1'b1;
        Op    = 2'b00;
        Funct = 6'b101000;
        #1;
        chk("fetch_irwrite", IRWrite, 8'd1);
        chk("fetch_nextpc",  NextPC,  8'd1);

        // DP immediate: DECODE, EXECUTEI, ALUWB, FETCH
        step();
        chk("dpi_decode",      state,   8'd1);
        chk("dpi_dec_irwrite", IRWrite, 8'd0);
        chk("dpi_dec_srca",    ALUSrcA, 8'd1);
        step();
        chk("dpi_execi",       state,   8'd7);
        chk("dpi_execi_srcb",  ALUSrcB, 8'd1);
        chk("dpi_execi_aluop", ALUOp,   8'd1);
        chk("dpi_execi_regw",  RegW,    8'd0);
        step();
        chk("dpi_aluwb",       state,   8'd8);
        chk("dpi_aluwb_regw",  RegW,    8'd1);
        chk("dpi_aluwb_res",   ResultSrc, 8'd0);
        step();
        chk("dpi_fetch",       state,   8'd0);

        // DP register, then async reset in the middle of EXECUTER
        Funct = 6'b000000;
        step();
        chk("dpr_decode",      state,   8'd1);
        step();
        chk("dpr_execr",       state,   8'd6);
        chk("dpr_execr_srcb",  ALUSrcB, 8'd0);
        #2 reset = 1'b0;
        #1;
        chk("async_rst_state",   state,   8'd0);
        chk("async_rst_irwrite", IRWrite, 8'd0);
        @(negedge clk);
        reset = 1'b1;

        // Load: FETCH, DECODE, MEMADR, MEMREAD, MEMWB
        Op    = 2'b01;
        Funct = 6'b000001;
        step();
        chk("ld_decode",      state,   8'd1);
        step();
        chk("ld_memadr",      state,   8'd2);
        chk("ld_memadr_srca", ALUSrcA, 8'd0);
        chk("ld_memadr_srcb", ALUSrcB, 8'd1);
        step();
        chk("ld_memread",     state,   8'd3);
        chk("ld_rd_adrsrc",   AdrSrc,  8'd1);
        chk("ld_rd_memreq",   MemReq,  8'd1);
        step();
        chk("ld_memwb",       state,   8'd4);
        chk("ld_wb_regw",     RegW,    8'd1);
        chk("ld_wb_res",      ResultSrc, 8'd1);
        step();
        chk("ld_fetch",       state,   8'd0);

        // Store
        Funct = 6'b000000;
        step();
        step();
        chk("st_memadr",      state,   8'd2);
        step();
        chk("st_memwrite",    state,   8'd5);
        chk("st_memw",        MemW,    8'd1);
        chk("st_memreq",      MemReq,  8'd1);
        chk("st_regw",        RegW,    8'd0);
`ifdef CTRL_FSM_WAITSTATE_EN
        HREADY = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("st_stall_state", state, 8'd5);
            chk("st_stall_memw",  MemW,  8'd1);
            chk("st_stall_adr",   AdrSrc, 8'd1);
        end
        HREADY = 1'b1;
`endif
        step();
        chk("st_fetch",       state,   8'd0);

        // FETCH with HREADY low for two cycles
        Op     = 2'b10;
        HREADY = 1'b0;
        #1;
`ifdef CTRL_FSM_WAITSTATE_EN
        chk("fst_nextpc0",    NextPC,  8'd0);
        chk("fst_irwrite0",   IRWrite, 8'd0);
        step();
        chk("fst_hold1",      state,   8'd0);
        chk("fst_nextpc1",    NextPC,  8'd0);
        step();
        chk("fst_hold2",      state,   8'd0);
        chk("fst_srcb2",      ALUSrcB, 8'd2);
        HREADY = 1'b1;
        #1;
        chk("fst_nextpc_go",  NextPC,  8'd1);
        step();
        chk("fst_decode",     state,   8'd1);
        chk("fst_nextpc_off", NextPC,  8'd0);
`else
        chk("fst_nextpc_unq", NextPC,  8'd1);
        step();
        chk("fst_decode",     state,   8'd1);
        HREADY = 1'b1;
`endif

        // Branch
        step();
        chk("br_state",       state,   8'd9);
        chk("br_branch",      Branch,  8'd1);
        chk("br_srcb",        ALUSrcB, 8'd1);
        chk("br_res",         ResultSrc, 8'd2);
        step();
        chk("br_fetch",       state,   8'd0);

        // Undefined: DECODE straight back to FETCH
        Op = 2'b11;
        step();
        chk("und_decode",     state,   8'd1);
        chk("und_regw",       RegW,    8'd0);
        chk("und_memw",       MemW,    8'd0);
        chk("und_branch",     Branch,  8'd0);
        step();
        chk("und_fetch",      state,   8'd0);
        chk("und_fetch_ir",   IRWrite, 8'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
